// File: rtl/cpu_types_pkg.sv
// Shared state/owner types and default limits for the memory arbiter.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    ERROR
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  localparam int STARVE_MAX_DEFAULT = 4;
  localparam int TIMEOUT_DEFAULT    = 255;

endpackage

// File: rtl/arb_priority.sv
// Instruction/data priority decision with anti-starvation counter.
// Data normally wins; once the instruction side has watched STARVE_MAX data
// grants go by, the next grant goes to the instruction side.
module arb_priority
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic instr_req,
  input  logic data_req,
  input  logic grant_en,
  output logic grant_any,
  output logic grant_instr
);

  logic [7:0] starve_cnt;
  logic       starved;

  // Pick the winner from the current requests and the starvation count.
  always_comb begin
    starved     = (int'(starve_cnt) >= STARVE_MAX);
    grant_any   = instr_req || data_req;
    grant_instr = instr_req && (!data_req || starved);
  end

  // Count data grants that overtook a waiting instruction request, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 8'd0;
    end else if (grant_en) begin
      if (grant_instr || !instr_req) begin
        starve_cnt <= 8'd0;
      end else if (!starved) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single RAM port.
// One access at a time: IDLE -> ACCESS (strobes held until ram_rdy) -> RESP
// (one-cycle hit to the owner) -> IDLE. Timeouts and illegal read+write
// requests lock the block in ERROR until reset.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic        ram_rdy,
  input  logic [31:0] ramload,
  output logic        err
);

  arb_state_t state;
  owner_t     owner;
  logic [7:0] wait_cnt;
  logic       req_lost;

  logic data_req;
  logic data_both;
  logic grant_en;
  logic grant_any;
  logic grant_instr;
  logic req_live;
  logic timeout_hit;

  // Request qualification, live-request tracking and timeout detection.
  always_comb begin
    data_req    = dREN ^ dWEN;
    data_both   = dREN && dWEN;
    grant_en    = (state == IDLE) && !data_both && grant_any;
    req_live    = (owner == OWN_I) ? iREN : (ramWEN ? dWEN : dREN);
    timeout_hit = (int'(wait_cnt) + 1) >= TIMEOUT;
  end

  arb_priority #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb_priority (
    .clk        (CLK),
    .rst        (RST),
    .instr_req  (iREN),
    .data_req   (data_req),
    .grant_en   (grant_en),
    .grant_any  (grant_any),
    .grant_instr(grant_instr)
  );

  // Arbiter FSM with all RAM-side and requester-side outputs registered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      owner    <= OWN_I;
      wait_cnt <= 8'd0;
      req_lost <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= 32'd0;
      ramstore <= 32'd0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      iload    <= 32'd0;
      dload    <= 32'd0;
      err      <= 1'b0;
    end else begin
      ihit  <= 1'b0;
      dhit  <= 1'b0;
      iload <= 32'd0;
      dload <= 32'd0;
      case (state)
        IDLE: begin
          if (data_both) begin
            state <= ERROR;
            err   <= 1'b1;
          end else if (grant_any) begin
            state    <= ACCESS;
            wait_cnt <= 8'd0;
            req_lost <= 1'b0;
            if (grant_instr) begin
              owner    <= OWN_I;
              ramREN   <= 1'b1;
              ramWEN   <= 1'b0;
              ramaddr  <= iaddr;
              ramstore <= 32'd0;
            end else begin
              owner    <= OWN_D;
              ramREN   <= dREN;
              ramWEN   <= dWEN;
              ramaddr  <= daddr;
              ramstore <= dstore;
            end
          end
        end
        ACCESS: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (ram_rdy) begin
            state  <= RESP;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            if (req_live && !req_lost) begin
              if (owner == OWN_I) begin
                ihit  <= 1'b1;
                iload <= ramload;
              end else begin
                dhit  <= 1'b1;
                dload <= ramWEN ? 32'd0 : ramload;
              end
            end
          end else if (timeout_hit) begin
            state  <= ERROR;
            err    <= 1'b1;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
          end else if (!req_live) begin
            req_lost <= 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state  <= ERROR;
          err    <= 1'b1;
          ramREN <= 1'b0;
          ramWEN <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter.
// The bench plays both requesters and the RAM. A transaction-level model keeps
// the pending requests of each side and the starvation rule in plain integers,
// and predicts the grant, RAM strobes, hit and returned data of each access.
module tb_mem_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 255;

  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        ihit;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dhit;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic        ram_rdy;
  logic [31:0] ramload;
  logic        err;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state: outstanding requests and starvation count.
  int          modelStarve;
  bit          iPend;
  logic [31:0] iPendAddr;
  bit          dPend;
  bit          dPendWrite;
  logic [31:0] dPendAddr;
  logic [31:0] dPendData;

  mem_arbiter #(
    .STARVE_MAX(STARVE_MAX),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iload   (iload),
    .ihit    (ihit),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .dload   (dload),
    .dhit    (dhit),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ram_rdy (ram_rdy),
    .ramload (ramload),
    .err     (err)
  );

  // 100 MHz-style free-running clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic driveRequests();
    iREN   = iPend;
    iaddr  = iPendAddr;
    dREN   = dPend && !dPendWrite;
    dWEN   = dPend && dPendWrite;
    daddr  = dPendAddr;
    dstore = dPendData;
  endtask

  task automatic newInstr();
    iPend     = 1'b1;
    iPendAddr = {4'h1, 28'($urandom)};
  endtask

  task automatic newData(input bit isWrite);
    dPend      = 1'b1;
    dPendWrite = isWrite;
    dPendAddr  = {4'h2, 28'($urandom)};
    dPendData  = $urandom;
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, ".ramREN"}, ramREN, 0);
    checkOutput({tag, ".ramWEN"}, ramWEN, 0);
    checkOutput({tag, ".ihit"}, ihit, 0);
    checkOutput({tag, ".dhit"}, dhit, 0);
  endtask

  task automatic doReset();
    RST     = 1'b1;
    iREN    = 1'b0;
    dREN    = 1'b0;
    dWEN    = 1'b0;
    iaddr   = 32'd0;
    daddr   = 32'd0;
    dstore  = 32'd0;
    ram_rdy = 1'b0;
    ramload = 32'd0;
    tick();
    tick();
    checkQuiet("reset");
    checkOutput("reset.err", err, 0);
    checkOutput("reset.ramaddr", ramaddr, 0);
    checkOutput("reset.iload", iload, 0);
    checkOutput("reset.dload", dload, 0);
    RST         = 1'b0;
    modelStarve = 0;
    iPend       = 1'b0;
    dPend       = 1'b0;
    iPendAddr   = 32'd0;
    dPendAddr   = 32'd0;
    dPendData   = 32'd0;
    dPendWrite  = 1'b0;
  endtask

  // One complete access from the IDLE cycle through the following IDLE cycle.
  // latency = ACCESS cycles before ram_rdy; dropReq = owner gives up mid-access.
  task automatic applyStimulus(input int latency, input bit dropReq, output bit sawInstr);
    bit          grantI;
    logic [31:0] expAddr;
    logic [31:0] loadVal;
    bit          expWrite;

    if (!iPend && ($urandom_range(0, 1) == 1)) newInstr();
    if (!dPend && ($urandom_range(0, 1) == 1)) newData($urandom_range(0, 1) == 1);
    if (!iPend && !dPend) newInstr();
    driveRequests();
    ram_rdy = 1'b0;

    grantI = iPend && (!dPend || modelStarve == STARVE_MAX);
    if (grantI || !iPend) modelStarve = 0;
    else if (modelStarve < STARVE_MAX) modelStarve++;
    expAddr  = grantI ? iPendAddr : dPendAddr;
    expWrite = !grantI && dPendWrite;
    loadVal  = $urandom;

    tick();
    sawInstr = (ramaddr[31:28] == 4'h1);
    checkOutput("access.ramaddr", ramaddr, expAddr);
    checkOutput("access.ramREN", ramREN, !expWrite);
    checkOutput("access.ramWEN", ramWEN, expWrite);
    if (!grantI) checkOutput("access.ramstore", ramstore, dPendData);
    checkOutput("access.hits", {ihit, dhit}, 0);

    if (dropReq) begin
      if (grantI) iPend = 1'b0;
      else dPend = 1'b0;
      driveRequests();
    end
    ram_rdy = (latency == 0);
    ramload = loadVal;
    for (int j = 1; j <= latency; j++) begin
      tick();
      checkOutput("wait.ramaddr", ramaddr, expAddr);
      checkOutput("wait.strobes", {ramREN, ramWEN}, {!expWrite, expWrite});
      if (!grantI) checkOutput("wait.ramstore", ramstore, dPendData);
      ram_rdy = (j == latency);
    end

    tick();
    ram_rdy = 1'b0;
    checkOutput("resp.strobes", {ramREN, ramWEN}, 0);
    checkOutput("resp.ihit", ihit, grantI && !dropReq);
    checkOutput("resp.dhit", dhit, !grantI && !dropReq);
    if (!dropReq) begin
      if (grantI) checkOutput("resp.iload", iload, loadVal);
      else checkOutput("resp.dload", dload, expWrite ? 32'd0 : loadVal);
      if (grantI) iPend = 1'b0;
      else dPend = 1'b0;
      driveRequests();
    end

    tick();
    checkOutput("idle.hits", {ihit, dhit}, 0);
    checkOutput("idle.loads", iload | dload, 0);
    checkOutput("idle.strobes", {ramREN, ramWEN}, 0);
  endtask

  initial begin
    bit saw;
    int run;
    int maxRun;

    doReset();

    // Single instruction fetch at minimum latency.
    iPend     = 1'b1;
    iPendAddr = 32'h0000_0040;
    driveRequests();
    ramload   = 32'hDEAD_BEEF;
    tick();
    checkOutput("fetch.ramaddr", ramaddr, 32'h40);
    checkOutput("fetch.ramREN", ramREN, 1);
    ram_rdy = 1'b1;
    tick();
    ram_rdy = 1'b0;
    checkOutput("fetch.ihit", ihit, 1);
    checkOutput("fetch.iload", iload, 32'hDEAD_BEEF);
    iPend = 1'b0;
    driveRequests();
    tick();
    checkOutput("fetch.ihitPulse", ihit, 0);

    // Data write with a slow RAM.
    doReset();
    dPend      = 1'b1;
    dPendWrite = 1'b1;
    dPendAddr  = 32'h0000_0100;
    dPendData  = 32'h1234_5678;
    driveRequests();
    tick();
    for (int j = 0; j < 3; j++) begin
      checkOutput("write.ramWEN", ramWEN, 1);
      checkOutput("write.ramstore", ramstore, 32'h1234_5678);
      checkOutput("write.ramaddr", ramaddr, 32'h100);
      ram_rdy = (j == 2);
      ramload = 32'hCAFE_F00D;
      if (j < 2) tick();
    end
    tick();
    ram_rdy = 1'b0;
    checkOutput("write.dhit", dhit, 1);
    checkOutput("write.dload", dload, 0);
    dPend = 1'b0;
    driveRequests();
    tick();
    checkOutput("write.dhitPulse", dhit, 0);

    // Both sides held, RAM always ready: instruction gets every fifth grant.
    doReset();
    run    = 0;
    maxRun = 0;
    for (int k = 0; k < 15; k++) begin
      if (!iPend) newInstr();
      if (!dPend) newData(1'b0);
      applyStimulus(0, 1'b0, saw);
      checkOutput("starve.grantOrder", saw, (k % 5) == 4);
      if (saw) run = 0;
      else run++;
      if (run > maxRun) maxRun = run;
    end
    checkOutput("starve.maxDataRun", maxRun, STARVE_MAX);

    // Random traffic against the model.
    doReset();
    for (int k = 0; k < 60; k++) begin
      applyStimulus($urandom_range(0, 4), $urandom_range(0, 7) == 0, saw);
    end

    // RAM never answers: ERROR after TIMEOUT access cycles, sticky until reset.
    doReset();
    newInstr();
    driveRequests();
    tick();
    repeat (TIMEOUT - 1) tick();
    checkOutput("timeout.errBefore", err, 0);
    checkOutput("timeout.ramRENBefore", ramREN, 1);
    tick();
    checkOutput("timeout.err", err, 1);
    checkQuiet("timeout");
    ram_rdy = 1'b1;
    dREN    = 1'b1;
    repeat (5) tick();
    checkOutput("timeout.errSticky", err, 1);
    checkQuiet("timeoutSticky");
    doReset();
    checkOutput("timeout.errCleared", err, 0);

    // ram_rdy in the very last allowed cycle still completes normally.
    newInstr();
    driveRequests();
    tick();
    repeat (TIMEOUT - 1) tick();
    ram_rdy = 1'b1;
    ramload = 32'h0BAD_CAFE;
    tick();
    ram_rdy = 1'b0;
    checkOutput("edge.err", err, 0);
    checkOutput("edge.ihit", ihit, 1);
    checkOutput("edge.iload", iload, 32'h0BAD_CAFE);

    // Reset asserted in the middle of an access.
    doReset();
    newData(1'b0);
    driveRequests();
    tick();
    checkOutput("midReset.ramREN", ramREN, 1);
    #2;
    RST = 1'b1;
    #1;
    checkQuiet("midReset");
    checkOutput("midReset.ramaddr", ramaddr, 0);
    checkOutput("midReset.err", err, 0);
    dPend = 1'b0;
    driveRequests();
    ram_rdy = 1'b1;
    tick();
    RST = 1'b0;
    modelStarve = 0;
    for (int j = 0; j < 4; j++) begin
      tick();
      checkQuiet("afterReset");
    end
    ram_rdy = 1'b0;
    applyStimulus(1, 1'b0, saw);

    // Read and write requested together.
    doReset();
    dREN = 1'b1;
    dWEN = 1'b1;
    tick();
    checkOutput("both.err", err, 1);
    checkQuiet("both");
    doReset();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
